// File: rtl/sram_ctl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_ctl_if: command, write-data, read-return and array pins of sram_ctl.
// Rev 1.0
// ------------------------------------------------------------------
interface sram_ctl_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [22:0]  cmd_addr;
  logic [3:0]   cmd_len;
  logic         wdata_valid;
  logic         wdata_ready;
  logic [255:0] wdata;
  logic         rdata_valid;
  logic         rdata_ready;
  logic [255:0] rdata;
  logic         rdata_last;
  logic         done;
  logic         err;
  logic [22:0]  sram_address;
  logic         sram_write_en;
  logic [255:0] sram_data_in;
  logic [255:0] sram_data_out;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
           rdata_ready, sram_data_out,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
           sram_address, sram_write_en, sram_data_in
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
           rdata_ready, sram_data_out,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done, err,
           sram_address, sram_write_en, sram_data_in
  );
endinterface
`default_nettype wire

// File: rtl/sram_ctl.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_ctl: 1-16 word burst controller with read-return FIFO; optional
// bounds check via SRAM_CTL_BOUNDS_CHECK_EN.  Rev 1.0
// ------------------------------------------------------------------
module sram_ctl #(
  parameter int ROWS       = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  sram_ctl_if.slave bus
);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_READ  = 2'd2;
`ifdef SRAM_CTL_BOUNDS_CHECK_EN
  localparam logic [1:0]  c_REJECT = 2'd3;
  localparam logic [23:0] c_LIMIT  = 24'(ROWS * 32);
`endif

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [22:0]           r_cur_addr;
  logic [4:0]            r_beats;
  logic                  r_pend;
  logic                  r_pend_last;
  logic                  r_done;
  logic [255:0]          r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic w_accept;
  logic w_wr_beat;
  logic w_issue;
  logic w_nonempty;
  logic w_pop;
  logic w_last_pop;

  assign w_accept   = (r_state == c_IDLE) && bus.cmd_valid;
  assign w_wr_beat  = (r_state == c_WRITE) && bus.wdata_valid;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty && bus.rdata_ready;
  assign w_last_pop = w_pop && r_fifo_last[r_rd_ptr];
  // The in-flight beat (r_pend) already owns a FIFO slot, so overflow is impossible.
  assign w_issue    = (r_state == c_READ) && (r_beats != 5'd0) &&
                      ((int'(r_count) + int'(r_pend)) < FIFO_DEPTH);

`ifdef SRAM_CTL_BOUNDS_CHECK_EN
  logic w_out_of_range;
  logic r_err;
  assign w_out_of_range = (({1'b0, bus.cmd_addr} + {20'd0, bus.cmd_len}) >= c_LIMIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (bus.cmd_valid) begin
          w_next = bus.cmd_write ? c_WRITE : c_READ;
`ifdef SRAM_CTL_BOUNDS_CHECK_EN
          if (w_out_of_range) w_next = c_REJECT;
`endif
        end
      end
      c_WRITE: begin
        if (w_wr_beat && (r_beats == 5'd1)) w_next = c_IDLE;
      end
      c_READ: begin
        if (w_last_pop) w_next = c_IDLE;
      end
`ifdef SRAM_CTL_BOUNDS_CHECK_EN
      c_REJECT: w_next = c_IDLE;
`endif
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready     = (r_state == c_IDLE);
    bus.wdata_ready   = (r_state == c_WRITE);
    bus.sram_write_en = w_wr_beat;
    bus.sram_data_in  = (r_state == c_WRITE) ? bus.wdata : '0;
    bus.sram_address  = r_cur_addr;
    bus.rdata_valid   = w_nonempty;
    bus.rdata         = w_nonempty ? r_fifo_data[r_rd_ptr] : '0;
    bus.rdata_last    = w_nonempty && r_fifo_last[r_rd_ptr];
    bus.done          = r_done;
`ifdef SRAM_CTL_BOUNDS_CHECK_EN
    bus.err           = r_err;
`else
    bus.err           = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_beats     <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_done <= (r_state != c_IDLE) && (w_next == c_IDLE);
      if (w_accept) begin
        r_cur_addr <= bus.cmd_addr;
        r_beats    <= {1'b0, bus.cmd_len} + 5'd1;
      end else if (w_wr_beat || w_issue) begin
        r_cur_addr <= r_cur_addr + 23'd1;
        r_beats    <= r_beats - 5'd1;
      end
      r_pend      <= w_issue;
      r_pend_last <= w_issue && (r_beats == 5'd1);
      if (r_pend) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({r_pend, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SRAM_CTL_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == c_REJECT);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (r_pend) begin
      r_fifo_data[r_wr_ptr] <= bus.sram_data_out;
      r_fifo_last[r_wr_ptr] <= r_pend_last;
    end
  end
endmodule
`default_nettype wire

// File: doc/sram_ctl.md
# sram_ctl

Burst controller upstream of the 256-bit banked SRAM array. It accepts single commands that cover 1–16 consecutive words, streams write data into the array or read data out of it, and absorbs the array's fixed one-cycle read latency with a small output FIFO. This lets read consumers apply backpressure without losing data. It drives the array's address, write-enable and write-data pins directly and samples its registered read-data output.

## Interface
Parameters:
- ROWS, 1024: rows per bank; the linear word space is ROWS*32 words.
- FIFO_DEPTH, 4: read-return FIFO entries; power of 2, at least 4.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  23  start word address; [4:0] bank, [22:5] row.
- cmd_len  in  4  beats minus 1.
- wdata_valid  in  1  write beat offered.
- wdata_ready  out  1  write beat accepted.
- wdata  in  256  write beat.
- rdata_valid  out  1  read beat available.
- rdata_ready  in  1  consumer takes beat.
- rdata  out  256  read beat.
- rdata_last  out  1  final beat of the burst.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  qualifies done; the command was rejected.
- sram_address  out  23  to array address.
- sram_write_en  out  1  to array write enable.
- sram_data_in  out  256  to array write data.
- sram_data_out  in  256  from array registered read data.

## Operation
- States are IDLE, WRITE, READ and REJECT. cmd_ready is 1 only in IDLE.
- On acceptance, the block latches cur_addr = cmd_addr and beats = cmd_len + 1, then moves to WRITE or READ. It moves to REJECT instead if the bounds check fails (see Configuration).
- Address increment: cur_addr advances by 1 per issued beat, modulo 2^23. The bank increments first and carries into the row.
- WRITE:
  - wdata_ready = 1.
  - sram_write_en = wdata_valid, sram_data_in = wdata, sram_address = cur_addr, all combinational.
  - Each handshake writes one word.
  - When the last beat is accepted, the next state is IDLE and done = 1 in the following cycle.
- READ issue rule: issue a read (sram_address = cur_addr, sram_write_en = 0) when there are beats left to issue and fifo_count + pend < FIFO_DEPTH. pend is the issue flag from the previous cycle.
- Return path: the beat issued in cycle N appears on sram_data_out in cycle N+1 and is pushed into the FIFO at the end of N+1. rdata_last is stored with the beat.
- Read completion: the block stays in READ until the last beat is popped (rdata_valid & rdata_ready & rdata_last). The next state is IDLE, with done = 1 in the following cycle.
- REJECT lasts one cycle. It makes no SRAM access and consumes no write data. It then returns to IDLE with done = 1 and err = 1. Upstream must not present write data for a rejected command.
- Outside WRITE, sram_write_en = 0. sram_address holds cur_addr at all times.
- Simultaneous FIFO push and pop leave the count unchanged. The FIFO never overflows because of the issue rule.

## Timing
- Values after reset: state IDLE, FIFO empty, pend 0, cur_addr 0, cmd_ready 1. All other outputs are 0.
- Reset asserted mid-burst abandons the burst immediately. No done pulse is produced, and an in-flight read return is discarded.
- Write throughput is 1 beat per cycle. A 16-beat write takes 16 cycles from the first wdata handshake, and done appears in the cycle after the last beat.
- Read latency is 2 cycles from issue to rdata_valid. Throughput is 1 beat per cycle while rdata_ready is held high.
- Command-to-command gap is at least 1 idle cycle; done coincides with cmd_ready = 1.

## Configuration
- SRAM_CTL_BOUNDS_CHECK_EN defined: a command is rejected through REJECT if cmd_addr + cmd_len >= ROWS*32. The comparison is 24-bit, so 23-bit wrap is also rejected.
- SRAM_CTL_BOUNDS_CHECK_EN undefined: the REJECT state is absent, err is tied to 0, and addresses wrap modulo 2^23 with no check.

## Test plan
- Write, len 3, addr 0x000020, data 0xA0..0xA3 → sram_write_en high for 4 cycles at 0x20..0x23; done in the next cycle, err = 0.
- Read of the same 4 words with rdata_ready = 1 → rdata 0xA0..0xA3 on consecutive cycles, first beat 2 cycles after issue, rdata_last on 0xA3, done in the next cycle.
- Read, len 15, with rdata_ready = 0 for 10 cycles → at most FIFO_DEPTH beats buffered and issue stalls; after release, all 16 beats arrive in order with none lost or duplicated.
- Bounds, macro defined, ROWS = 1024: addr 0x007FFE, len 3 → no SRAM access, done = 1, err = 1 one cycle after acceptance. Macro undefined: same command writes 0x7FFE, 0x7FFF, 0x8000, 0x8001.
- Wrap, macro undefined: addr 0x7FFFFF, len 1 → accesses at 0x7FFFFF then 0x000000.
- rst asserted mid-read with 2 beats in the FIFO → rdata_valid = 0 and cmd_ready = 1 immediately, no done pulse, and the next command behaves normally.
